// File: rtl/ab_seq_pkg.sv
// Shared types and constants for the a/b sequence generator and its detector.
// Stimulus vectors are packed as {a, b}.
package ab_seq_pkg;

  typedef enum logic [1:0] {
    st0 = 2'd0,
    st1 = 2'd1,
    st2 = 2'd2,
    st3 = 2'd3
  } stlist;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_e;

  localparam logic [1:0] AB_ST0  = 2'b10;
  localparam logic [1:0] AB_ST1  = 2'b01;
  localparam logic [1:0] AB_ST2  = 2'b11;
  localparam logic [1:0] AB_ST3  = 2'b10;
  localparam logic [1:0] AB_IDLE = 2'b00;

  // Drive that moves the detector out of state s.
  function automatic logic [1:0] step_ab(stlist s);
    case (s)
      st0:     return AB_ST0;
      st1:     return AB_ST1;
      st2:     return AB_ST2;
      default: return AB_ST3;
    endcase
  endfunction

  // The loop order matches the encoding, so the 2-bit increment wraps st3 to st0.
  function automatic stlist next_st(stlist s);
    return stlist'(s + 2'd1);
  endfunction

endpackage

// File: rtl/ab_seq_gen_tick_div.sv
// Clock-enable divider: counts 0..DIV-1 while enabled and pulses tick on DIV-1.
// clear forces the count back to 0 so a new run starts on a full period.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = enable && (cnt_q == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ab_seq_gen.sv
// Paced a/b stimulus driver that walks the detector loop st0->st1->st2->st3 a
// commanded number of times, with a mirror of the detector state it should reach.
module ab_seq_gen
  import ab_seq_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int LEN_W = 8
) (
  input  logic             clki,
  input  logic             rsti_n,
  input  logic             start,
  input  logic [LEN_W-1:0] loops,
  output logic             busy,
  output logic             done,
  output logic             a,
  output logic             b,
  output logic [1:0]       st_mirror,
  output logic [LEN_W-1:0] loop_cnt
);

  gen_state_e       state_q, state_d;
  stlist            st_q, st_d;
  logic             a_q, a_d, b_q, b_d, done_q, done_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, loops_q, loops_d;
  logic             tick;

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk    (clki),
    .rst_n  (rsti_n),
    .clear  (state_q == IDLE),
    .enable (state_q == RUN),
    .tick   (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    loops_d = loops_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          loops_d = loops;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          // Completion only happens at a loop boundary, so a/b never stop mid-loop.
          if (cnt_q == loops_q && st_q == st0) begin
            {a_d, b_d} = AB_IDLE;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            {a_d, b_d} = step_ab(st_q);
            st_d       = next_st(st_q);
            if (st_q == st3) cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: loops_q is reset as well even though it is only read in RUN; no flop is left to power up as X.
  always_ff @(posedge clki or negedge rsti_n) begin
    if (!rsti_n) begin
      state_q <= IDLE;
      st_q    <= st0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      loops_q <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      loops_q <= loops_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign a         = a_q;
  assign b         = b_q;
  assign st_mirror = st_q;
  assign loop_cnt  = cnt_q;

endmodule
